// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: loader FSM states, memory geometry and stat codes.
package y86_pkg;

  localparam int MEM_BYTES   = 1024;
  localparam int FETCH_BYTES = 10;
  localparam int ADDR_W      = 10;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    DATA = 3'd1,
    CSUM = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } loader_state_t;

  localparam logic [3:0] AOK = 4'b1000;
  localparam logic [3:0] HLT = 4'b0100;
  localparam logic [3:0] ADR = 4'b0010;
  localparam logic [3:0] INS = 4'b0001;

endpackage

// File: rtl/imem_bank.sv
// Byte-wide instruction RAM: one synchronous write port and a combinational
// fetch window that reads zero for any byte at or beyond the end of memory.
module imem_bank #(
  parameter int MEM_BYTES   = 1024,
  parameter int ADDR_W      = 10,
  parameter int FETCH_BYTES = 10
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [7:0]                   wdata,
  input  logic [63:0]                  pc,
  output logic [0:8*FETCH_BYTES-1]     rdata
);

  logic [7:0] mem_r [MEM_BYTES];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // The extra sum bit keeps a PC near 2^64 from wrapping into valid memory.
  for (genvar k = 0; k < FETCH_BYTES; k++) begin : g_win
    logic [64:0] addr_s;
    assign addr_s = {1'b0, pc} + 65'(k);
    assign rdata[8*k +: 8] = (addr_s < 65'(MEM_BYTES)) ? mem_r[addr_s[ADDR_W-1:0]] : 8'h00;
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader owning the instruction memory; holds the
// core stalled until a frame has been written and its XOR checksum verified.
module imem_loader #(
  parameter int MEM_BYTES   = 1024,
  parameter int ADDR_W      = 10,
  parameter int FETCH_BYTES = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic [63:0]              pc,
  output logic [0:8*FETCH_BYTES-1] curr_inst,
  output logic                     imem_err,
  output logic                     cpu_run,
  output logic                     load_err,
  output logic [10:0]              bytes_loaded
);

  import y86_pkg::*;

  loader_state_t state_r, state_nx_s;
  logic [1:0]    hdr_cnt_r;
  logic [15:0]   base_r, len_r, idx_r;
  logic [7:0]    xor_r;
  logic [10:0]   bytes_loaded_r;
  logic          we_s;
  logic [15:0]   len_full_s;
  logic [16:0]   end_s;

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nx_s = state_r;
    in_ready   = 1'b0;
    cpu_run    = 1'b0;
    load_err   = 1'b0;
    we_s       = 1'b0;
    len_full_s = {len_r[15:8], in_data};
    end_s      = {1'b0, base_r} + {1'b0, len_full_s};
    case (state_r)
      HDR: begin
        in_ready = 1'b1;
        if (in_valid && hdr_cnt_r == 2'd3) begin
          if (base_r[15:ADDR_W] != '0) begin
            state_nx_s = ERR;
          end else if (len_full_s == 16'd0) begin
            state_nx_s = CSUM;
          end else if (end_s > 17'(MEM_BYTES)) begin
            state_nx_s = ERR;
          end else begin
            state_nx_s = DATA;
          end
        end else begin
          state_nx_s = HDR;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        we_s     = in_valid;
        if (in_valid && idx_r == len_r - 16'd1) begin
          state_nx_s = CSUM;
        end else begin
          state_nx_s = DATA;
        end
      end
      CSUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx_s = (in_data == xor_r) ? DONE : ERR;
        end else begin
          state_nx_s = CSUM;
        end
      end
      DONE:    cpu_run  = 1'b1;
      ERR:     load_err = 1'b1;
      default: state_nx_s = ERR;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= HDR;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Header capture, payload index, running XOR and the saturating byte count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_cnt_r      <= 2'd0;
      base_r         <= 16'd0;
      len_r          <= 16'd0;
      idx_r          <= 16'd0;
      xor_r          <= 8'd0;
      bytes_loaded_r <= 11'd0;
    end else if (state_r == HDR && in_valid) begin
      hdr_cnt_r <= hdr_cnt_r + 2'd1;
      case (hdr_cnt_r)
        2'd0:    base_r[15:8] <= in_data;
        2'd1:    base_r[7:0]  <= in_data;
        2'd2:    len_r[15:8]  <= in_data;
        default: len_r[7:0]   <= in_data;
      endcase
    end else if (we_s) begin
      idx_r <= idx_r + 16'd1;
      xor_r <= xor_r ^ in_data;
      if (bytes_loaded_r < 11'(MEM_BYTES)) begin
        bytes_loaded_r <= bytes_loaded_r + 11'd1;
      end
    end
  end

  assign bytes_loaded = bytes_loaded_r;
  assign imem_err     = (pc > 64'(MEM_BYTES - FETCH_BYTES));

  imem_bank #(
    .MEM_BYTES  (MEM_BYTES),
    .ADDR_W     (ADDR_W),
    .FETCH_BYTES(FETCH_BYTES)
  ) u_bank (
    .clk  (clk),
    .we   (we_s),
    .waddr(base_r[ADDR_W-1:0] + idx_r[ADDR_W-1:0]),
    .wdata(in_data),
    .pc   (pc),
    .rdata(curr_inst)
  );

endmodule
